seq_alu: RTL and testbench

- Multi-cycle 8-bit ALU that sits directly upstream of the accumulator register.
- Takes the accumulator value as operand A and a second operand B, and computes the result.
- Drives the accumulator's data input with `result` and its enable input with `ac_en`.
- Simple ops complete in 1 cycle; MUL and DIV iterate one bit per cycle.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu_iter.sv | 94 +++++++++
 rtl/seq_alu.sv | 169 ++++++++++++++++
 tb/tb_seq_alu.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU (seq_alu and seq_alu_iter).
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSB = 3'b101,
    OP_MUL   = 3'b110,
    OP_DIV   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the accumulator-side controller and seq_alu.
interface seq_alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             ac_en;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, ac_en, result, carry, zero, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, ac_en, result, carry, zero, err
  );

endinterface

// File: rtl/seq_alu_iter.sv
// Bit-serial datapath: shift-add multiplier and, with SEQ_ALU_DIV_EN defined, a restoring divider.
// {hi, lo} holds product (MUL) or remainder/quotient (DIV); lo_next/hi_next expose the post-step value.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_mul,
  input  logic             load_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             step,
  output logic             last,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [CW-1:0]    cnt_reg;
  logic             running_reg;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  // Multiplier bits are consumed from lo while the product shifts in from the top.
  assign add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_hi  = add_sum[WIDTH:1];
  assign mul_lo  = {add_sum[0], lo_reg[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
  logic             div_reg;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // Remainder stays below the divisor, so the trial difference always fits in WIDTH bits.
  assign shifted = {hi_reg, lo_reg[WIDTH-1]};
  assign fits    = shifted >= {1'b0, opnd_reg};
  assign rem_sub = shifted[WIDTH-1:0] - opnd_reg;
  assign div_hi  = fits ? rem_sub : shifted[WIDTH-1:0];
  assign div_lo  = {lo_reg[WIDTH-2:0], fits};

  assign hi_next = div_reg ? div_hi : mul_hi;
  assign lo_next = div_reg ? div_lo : mul_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= 1'b0;
    end else if (load_mul || load_div) begin
      div_reg <= load_div;
    end
  end
`else
  assign hi_next = mul_hi;
  assign lo_next = mul_lo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg      <= '0;
      lo_reg      <= '0;
      opnd_reg    <= '0;
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (load_mul || load_div) begin
      hi_reg      <= '0;
      lo_reg      <= load_div ? a : b;
      opnd_reg    <= load_div ? b : a;
      cnt_reg     <= '0;
      running_reg <= 1'b1;
    end else if (running_reg) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg + CW'(1);
      if (last) begin
        running_reg <= 1'b0;
      end
    end
  end

  assign step = running_reg;
  assign last = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU driving the accumulator: 1-cycle logic/arith ops, bit-serial MUL/DIV.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise opcode DIV returns 0 with err set.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);

  alu_state_e       state_reg;
  alu_state_e       state_next;
  alu_op_e          op_in;
  logic             accept;
  logic             load_mul;
  logic             load_div;

  logic             iter_step;
  logic             iter_last;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] fast_res;
  logic             fast_carry;
  logic             fast_err;

  logic             fin_load;
  logic [WIDTH-1:0] fin_res;
  logic             fin_carry;
  logic             fin_err;

  logic [WIDTH-1:0] result_reg;
  alu_flags_t       flags_reg;

  assign op_in    = alu_op_e'(bus.op);
  assign accept   = bus.start && (state_reg == ST_IDLE);
  assign load_mul = accept && (op_in == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
  assign load_div = accept && (op_in == OP_DIV) && (bus.b != '0);
`else
  assign load_div = 1'b0;
`endif

  seq_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_mul (load_mul),
    .load_div (load_div),
    .a        (bus.a),
    .b        (bus.b),
    .step     (iter_step),
    .last     (iter_last),
    .lo_next  (iter_lo),
    .hi_next  (iter_hi)
  );

  assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    fast_res   = '0;
    fast_carry = 1'b0;
    fast_err   = 1'b0;
    case (op_in)
      OP_ADD: begin
        fast_res   = sum_ext[WIDTH-1:0];
        fast_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        fast_res   = diff_ext[WIDTH-1:0];
        fast_carry = diff_ext[WIDTH];
      end
      OP_AND:   fast_res = bus.a & bus.b;
      OP_OR:    fast_res = bus.a | bus.b;
      OP_XOR:   fast_res = bus.a ^ bus.b;
      OP_PASSB: fast_res = bus.b;
      OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
        // Only the divide-by-zero case reaches the fast path.
        fast_res = '1;
`endif
        fast_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (load_mul) begin
            state_next = ST_MUL;
          end else if (load_div) begin
            state_next = ST_DIV;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_reg == ST_MUL) || (state_reg == ST_DIV);
    bus.done  = (state_reg == ST_DONE);
    bus.ac_en = (state_reg == ST_DONE);
  end

  // Result/flags are captured on the edge that enters DONE, so they are stable while done is high.
  always_comb begin
    fin_load  = 1'b0;
    fin_res   = fast_res;
    fin_carry = fast_carry;
    fin_err   = fast_err;
    if (accept && !load_mul && !load_div) begin
      fin_load = 1'b1;
    end else if (iter_step && iter_last) begin
      fin_load  = 1'b1;
      fin_res   = iter_lo;
      fin_carry = |iter_hi;
      fin_err   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      flags_reg  <= '0;
    end else if (fin_load) begin
      result_reg      <= fin_res;
      flags_reg.carry <= fin_carry;
      flags_reg.zero  <= (fin_res == '0);
      flags_reg.err   <= fin_err;
    end
  end

  assign bus.result = result_reg;
  assign bus.carry  = flags_reg.carry;
  assign bus.zero   = flags_reg.zero;
  assign bus.err    = flags_reg.err;

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) bus.done |-> !bus.busy);
  a_done_single:   assert property (@(posedge clk) disable iff (!rst_n)
                                    (state_reg == ST_DONE) |=> (state_reg == ST_IDLE));

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, corner sequences, random ops vs. arithmetic model.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(8)) bus();

  seq_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       err;
    int         lat;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  // Reference: plain integer arithmetic on the opcode meaning.
  function automatic exp_t model(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int full;
    e.res = 8'h00; e.carry = 1'b0; e.err = 1'b0; e.lat = 1;
    case (op)
      3'd0: begin full = ua + ub; e.res = 8'(full); e.carry = (full > 255); end
      3'd1: begin e.res = 8'(ua - ub); e.carry = (ua < ub); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = b;
      3'd6: begin full = ua * ub; e.res = 8'(full); e.carry = ((full / 256) != 0); e.lat = 9; end
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (ub == 0) begin
          e.res = 8'hFF; e.err = 1'b1;
        end else begin
          e.res = 8'(ua / ub); e.carry = ((ua % ub) != 0); e.lat = 9;
        end
`else
        e.res = 8'h00; e.err = 1'b1;
`endif
      end
    endcase
    e.zero = (e.res == 8'h00);
    return e;
  endfunction

  function automatic vec_t mk(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] res,
                              logic c, logic z, logic er, int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.e.res = res; v.e.carry = c; v.e.zero = z; v.e.err = er; v.e.lat = lat;
    return v;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [3:0] flags, output int lat,
                        output int busy_cycles, output logic busy_at_done, output logic done_after);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    res          = bus.result;
    flags        = {bus.ac_en, bus.carry, bus.zero, bus.err};
    busy_at_done = bus.busy;
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic apply(string name, logic [2:0] op, logic [7:0] a, logic [7:0] b, exp_t e);
    logic [7:0] res;
    logic [3:0] flags;
    int lat, busy_cycles;
    logic busy_at_done, done_after;
    run_op(op, a, b, res, flags, lat, busy_cycles, busy_at_done, done_after);
    $display("%s op=%0d a=%02h b=%02h -> result=%02h ac_en/c/z/e=%b lat=%0d busy=%0d",
             name, op, a, b, res, flags, lat, busy_cycles);
    chk({name, ".result"}, 32'(res), 32'(e.res));
    chk({name, ".flags"}, 32'(flags), 32'({1'b1, e.carry, e.zero, e.err}));
    chk({name, ".latency"}, 32'(lat), 32'(e.lat));
    chk({name, ".busy_cycles"}, 32'(busy_cycles), 32'((e.lat == 9) ? 8 : 0));
    chk({name, ".done_pulse"}, 32'({busy_at_done, done_after}), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int dones;
    logic [7:0] cap_res;
    logic cap_carry;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00;

    vecs.push_back(mk(3'd0, 8'hF0, 8'h20, 8'h10, 1, 0, 0, 1));
    vecs.push_back(mk(3'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1));
    vecs.push_back(mk(3'd1, 8'h05, 8'h07, 8'hFE, 1, 0, 0, 1));
    vecs.push_back(mk(3'd1, 8'h07, 8'h07, 8'h00, 0, 1, 0, 1));
    vecs.push_back(mk(3'd2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 1));
    vecs.push_back(mk(3'd3, 8'hF0, 8'h0F, 8'hFF, 0, 0, 0, 1));
    vecs.push_back(mk(3'd4, 8'hFF, 8'h0F, 8'hF0, 0, 0, 0, 1));
    vecs.push_back(mk(3'd5, 8'h12, 8'h00, 8'h00, 0, 1, 0, 1));
    vecs.push_back(mk(3'd6, 8'h0D, 8'h0B, 8'h8F, 0, 0, 0, 9));
    vecs.push_back(mk(3'd6, 8'h20, 8'h10, 8'h00, 1, 1, 0, 9));
    vecs.push_back(mk(3'd6, 8'hFF, 8'hFF, 8'h01, 1, 0, 0, 9));
`ifdef SEQ_ALU_DIV_EN
    vecs.push_back(mk(3'd7, 8'h64, 8'h07, 8'h0E, 1, 0, 0, 9));
    vecs.push_back(mk(3'd7, 8'h10, 8'h04, 8'h04, 0, 0, 0, 9));
    vecs.push_back(mk(3'd7, 8'h03, 8'h09, 8'h00, 1, 1, 0, 9));
    vecs.push_back(mk(3'd7, 8'h55, 8'h00, 8'hFF, 0, 0, 1, 1));
`else
    vecs.push_back(mk(3'd7, 8'h64, 8'h07, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(3'd7, 8'h55, 8'h00, 8'h00, 0, 1, 1, 1));
`endif

    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({bus.busy, bus.done, bus.ac_en, bus.result, bus.carry, bus.zero, bus.err}), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
    end

    // start held high: the DONE cycle swallows it, so one op per two cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 8'h01; bus.b = 8'h02;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    $display("back_to_back: %0d done pulses in 6 cycles, result=%02h", dones, bus.result);
    chk("b2b_done_count", 32'(dones), 32'd3);
    chk("b2b_result", 32'(bus.result), 32'h03);

    // ADD requested while MUL is busy must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 8'h0D; bus.b = 8'h0B;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 8'h01; bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0; cap_res = 8'h00; cap_carry = 1'b1;
    repeat (12) begin
      if (bus.done) begin
        dones++; cap_res = bus.result; cap_carry = bus.carry;
      end
      @(negedge clk);
    end
    $display("busy_ignore: %0d done pulses, result=%02h carry=%b", dones, cap_res, cap_carry);
    chk("busy_ignore_done_count", 32'(dones), 32'd1);
    chk("busy_ignore_result", 32'(cap_res), 32'h8F);
    chk("busy_ignore_carry", 32'(cap_carry), 32'h0);
    chk("busy_ignore_held", 32'(bus.result), 32'h8F);

    // Reset in MUL cycle 4: outputs clear asynchronously.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 8'h0D; bus.b = 8'h0B;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    $display("mid_mul_reset: busy=%b done=%b result=%02h", bus.busy, bus.done, bus.result);
    chk("rst_mid_mul_outputs",
        32'({bus.busy, bus.done, bus.ac_en, bus.result, bus.carry, bus.zero, bus.err}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset_add", 3'd0, 8'h01, 8'h01, model(3'd0, 8'h01, 8'h01));

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      apply($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
